// File: rtl/keycode_action_decoder_if.sv
// Action-event valid/ready handshake between the keycode decoder (master) and the piece-control FSM (slave).
interface keycode_action_decoder_if;
  logic       act_valid;
  logic [2:0] act_code;
  logic       act_ready;

  modport master (output act_valid, output act_code, input act_ready);
  modport slave  (input act_valid, input act_code, output act_ready);
endinterface

// File: rtl/keycode_action_decoder.sv
// Decodes the Nios keycode PIO word into Tetris action events with DAS/ARR auto-repeat.
// Optional feature: define KEYDEC_DROPCNT_EN to add the dbg_drop_cnt coalesced-event counter port.
module keycode_action_decoder #(
  parameter logic [7:0]  KEY_LEFT  = 8'h04,
  parameter logic [7:0]  KEY_RIGHT = 8'h07,
  parameter logic [7:0]  KEY_DOWN  = 8'h16,
  parameter logic [7:0]  KEY_ROT   = 8'h1A,
  parameter logic [7:0]  KEY_DROP  = 8'h2C,
  parameter int unsigned DAS_CYC   = 8_500_000,
  parameter int unsigned ARR_CYC   = 2_500_000,
  parameter int unsigned CNT_W     = 24
) (
  input  logic                     clk_clk,
  input  logic                     reset_reset_n,
  input  logic [15:0]              keycode_export,
  keycode_action_decoder_if.master act_if,
  output logic [4:0]               key_held
`ifdef KEYDEC_DROPCNT_EN
  , output logic [7:0]             dbg_drop_cnt
`endif
);

  localparam int unsigned NA = 5;  // actions: 0 left, 1 right, 2 down, 3 rotate, 4 hard-drop
  localparam int unsigned NR = 3;  // auto-repeating actions: left, right, down

  typedef enum logic [1:0] {S_IDLE, S_DAS, S_ARR} rep_state_e;

  rep_state_e       r_state [NR];
  rep_state_e       w_state_nxt [NR];
  logic [CNT_W-1:0] r_cnt [NR];
  logic [CNT_W-1:0] w_cnt_nxt [NR];
  logic [NR-1:0]    w_rep_in;
  logic [NR-1:0]    w_rep_evt;

  logic [NA-1:0]    w_held;
  logic [NA-1:0]    r_key_held;
  logic [NA-1:0]    w_evt;
  logic [NA-1:0]    r_pend;
  logic [NA-1:0]    w_pend_nxt;
  logic [NA-1:0]    w_clr;
  logic             w_hs;
  logic             r_act_valid;
  logic             w_valid_nxt;
  logic [2:0]       r_act_code;
  logic [2:0]       w_code_nxt;

  // An empty slot (8'h00) never matches, and a key in both slots is still one key.
  function automatic logic f_match(input logic [15:0] kc, input logic [7:0] key);
    return (key != 8'h00) && ((kc[7:0] == key) || (kc[15:8] == key));
  endfunction

  assign w_held = {f_match(keycode_export, KEY_DROP), f_match(keycode_export, KEY_ROT),
                   f_match(keycode_export, KEY_DOWN), f_match(keycode_export, KEY_RIGHT),
                   f_match(keycode_export, KEY_LEFT)};

  // Left and right cancel each other out while both are held.
  assign w_rep_in = {w_held[2], w_held[1] & ~w_held[0], w_held[0] & ~w_held[1]};

  // Repeat FSMs: release always wins over a counter expiry.
  always_comb begin
    for (int i = 0; i < NR; i++) begin
      w_state_nxt[i] = r_state[i];
      w_cnt_nxt[i]   = r_cnt[i];
      w_rep_evt[i]   = 1'b0;
      if (!w_rep_in[i]) begin
        w_state_nxt[i] = S_IDLE;
        w_cnt_nxt[i]   = '0;
      end else begin
        case (r_state[i])
          S_IDLE: begin
            w_rep_evt[i]   = 1'b1;
            w_cnt_nxt[i]   = CNT_W'(DAS_CYC - 1);
            w_state_nxt[i] = S_DAS;
          end
          S_DAS, S_ARR: begin
            if (r_cnt[i] == '0) begin
              w_rep_evt[i]   = 1'b1;
              w_cnt_nxt[i]   = CNT_W'(ARR_CYC - 1);
              w_state_nxt[i] = S_ARR;
            end else begin
              w_cnt_nxt[i] = r_cnt[i] - CNT_W'(1);
            end
          end
          default: begin
            w_state_nxt[i] = S_IDLE;
            w_cnt_nxt[i]   = '0;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      for (int i = 0; i < NR; i++) begin
        r_state[i] <= S_IDLE;
        r_cnt[i]   <= '0;
      end
    end else begin
      for (int i = 0; i < NR; i++) begin
        r_state[i] <= w_state_nxt[i];
        r_cnt[i]   <= w_cnt_nxt[i];
      end
    end
  end

  // Rotate and hard-drop fire once per press; r_key_held doubles as the previous-held sample.
  assign w_evt = {w_held[4] & ~r_key_held[4], w_held[3] & ~r_key_held[3], w_rep_evt};
  assign w_hs  = r_act_valid & act_if.act_ready;
  assign w_clr = w_hs ? (NA'(1) << r_act_code) : '0;

  // A new event for the action being accepted re-arms its pending bit.
  assign w_pend_nxt = (r_pend & ~w_clr) | w_evt;

  // Issue: only when the output slot is free, so a presented action is never preempted.
  always_comb begin
    w_valid_nxt = r_act_valid;
    w_code_nxt  = r_act_code;
    if (!r_act_valid || w_hs) begin
      w_valid_nxt = |w_pend_nxt;
      if      (w_pend_nxt[4]) w_code_nxt = 3'd4;
      else if (w_pend_nxt[3]) w_code_nxt = 3'd3;
      else if (w_pend_nxt[0]) w_code_nxt = 3'd0;
      else if (w_pend_nxt[1]) w_code_nxt = 3'd1;
      else if (w_pend_nxt[2]) w_code_nxt = 3'd2;
    end
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      r_key_held  <= '0;
      r_pend      <= '0;
      r_act_valid <= 1'b0;
      r_act_code  <= 3'd0;
    end else begin
      r_key_held  <= w_held;
      r_pend      <= w_pend_nxt;
      r_act_valid <= w_valid_nxt;
      r_act_code  <= w_code_nxt;
    end
  end

  assign act_if.act_valid = r_act_valid;
  assign act_if.act_code  = r_act_code;
  assign key_held         = r_key_held;

`ifdef KEYDEC_DROPCNT_EN
  logic [NA-1:0] w_coal;
  logic [2:0]    w_coal_n;
  logic [8:0]    w_drop_sum;
  logic [7:0]    r_drop_cnt;

  // Events landing on a pending bit that stays set are lost to coalescing.
  assign w_coal = w_evt & r_pend & ~w_clr;

  always_comb begin
    w_coal_n = 3'd0;
    for (int i = 0; i < NA; i++) begin
      w_coal_n = w_coal_n + 3'(w_coal[i]);
    end
    w_drop_sum = 9'(r_drop_cnt) + 9'(w_coal_n);
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      r_drop_cnt <= 8'h00;
    end else begin
      r_drop_cnt <= w_drop_sum[8] ? 8'hFF : w_drop_sum[7:0];
    end
  end

  assign dbg_drop_cnt = r_drop_cnt;
`endif

endmodule

// File: tb/tb_keycode_action_decoder.sv
// Self-checking bench for keycode_action_decoder with short DAS/ARR timing and a behavioural model.
module tb_keycode_action_decoder;

  localparam int unsigned DAS = 8;
  localparam int unsigned ARR = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] keycode;
  logic [4:0]  key_held;
`ifdef KEYDEC_DROPCNT_EN
  logic [7:0]  dbg_drop_cnt;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  keycode_action_decoder_if u_if ();

  keycode_action_decoder #(
    .DAS_CYC (DAS),
    .ARR_CYC (ARR),
    .CNT_W   (4)
  ) dut (
    .clk_clk        (clk),
    .reset_reset_n  (rst_n),
    .keycode_export (keycode),
    .act_if         (u_if),
    .key_held       (key_held)
`ifdef KEYDEC_DROPCNT_EN
    , .dbg_drop_cnt (dbg_drop_cnt)
`endif
  );

  // Behavioural model: press age per repeating action, pending set, presented action.
  int       m_age [3];
  bit       m_valid;
  int       m_code;
  bit [4:0] m_held;
  bit [4:0] m_pend;
  int       prio [5] = '{4, 3, 0, 1, 2};
  logic [7:0] key_tab [5] = '{8'h04, 8'h07, 8'h16, 8'h1A, 8'h2C};

  always @(posedge clk or negedge rst_n) begin
    bit [4:0] h;
    bit [4:0] ev;
    bit [2:0] eff;
    bit       hs;
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) m_age[i] = -1;
      m_valid = 0; m_code = 0; m_held = '0; m_pend = '0;
    end else begin
      for (int a = 0; a < 5; a++) h[a] = (keycode[7:0] == key_tab[a]) || (keycode[15:8] == key_tab[a]);
      eff = {h[2], h[1] && !h[0], h[0] && !h[1]};
      for (int r = 0; r < 3; r++) begin
        if (eff[r]) begin
          m_age[r] = (m_age[r] < 0) ? 0 : m_age[r] + 1;
          ev[r] = (m_age[r] == 0) ||
                  (m_age[r] >= int'(DAS) && ((m_age[r] - int'(DAS)) % int'(ARR)) == 0);
        end else begin
          m_age[r] = -1;
          ev[r] = 0;
        end
      end
      ev[3] = h[3] && !m_held[3];
      ev[4] = h[4] && !m_held[4];
      hs = m_valid && u_if.act_ready;
      if (hs) m_pend[m_code] = 0;
      m_pend = m_pend | ev;
      if (!m_valid || hs) begin
        m_valid = 0;
        for (int p = 0; p < 5; p++) begin
          if (!m_valid && m_pend[prio[p]]) begin
            m_valid = 1;
            m_code  = prio[p];
          end
        end
      end
      m_held = h;
    end
  end

  // Apply one cycle of inputs; on return the outputs of the following cycle are visible.
  task automatic drive(input logic [15:0] kc, input logic rdy);
    keycode = kc;
    u_if.act_ready = rdy;
    @(negedge clk);
  endtask

  task automatic settle();
    repeat (8) drive(16'h0000, 1'b1);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    keycode = 16'h0004;
    u_if.act_ready = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (u_if.act_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b want=0", u_if.act_valid); end
    checks++;
    if (u_if.act_code !== 3'd0) begin errors++; $display("FAIL reset_code got=%0d want=0", u_if.act_code); end
    checks++;
    if (key_held !== 5'b0) begin errors++; $display("FAIL reset_held got=%b want=00000", key_held); end
    keycode = 16'h0000;
    rst_n = 1'b1;
    settle();
  endtask

  task automatic test_das_repeat();
    int hits[$];
    int exp_c[4] = '{1, 1 + DAS, 1 + DAS + ARR, 1 + DAS + 2 * ARR};
    for (int i = 0; i < 20; i++) begin
      drive(16'h0004, 1'b1);
      if (u_if.act_valid === 1'b1) begin
        hits.push_back(i + 1);
        checks++;
        if (u_if.act_code !== 3'd0) begin errors++; $display("FAIL das_code got=%0d want=0", u_if.act_code); end
      end
    end
    checks++;
    if (hits.size() != 4) begin
      errors++; $display("FAIL das_event_count got=%0d want=4", hits.size());
    end else begin
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (hits[k] != exp_c[k]) begin errors++; $display("FAIL das_event_cycle got=%0d want=%0d", hits[k], exp_c[k]); end
      end
    end
    settle();
  endtask

  task automatic test_cancel();
    int n = 0;
    repeat (3) drive(16'h0004, 1'b1);
    for (int i = 0; i < 20; i++) begin
      drive(16'h0704, 1'b1);
      if (u_if.act_valid === 1'b1) n++;
    end
    checks++;
    if (n != 0) begin errors++; $display("FAIL cancel_events got=%0d want=0", n); end
    checks++;
    if (key_held !== 5'b00011) begin errors++; $display("FAIL cancel_held got=%b want=00011", key_held); end
    drive(16'h0007, 1'b1);
    checks++;
    if (u_if.act_valid !== 1'b1 || u_if.act_code !== 3'd1) begin
      errors++; $display("FAIL cancel_right got=%b/%0d want=1/1", u_if.act_valid, u_if.act_code);
    end
    settle();
  endtask

  task automatic test_priority();
    int bad = 0;
    drive(16'h2C1A, 1'b0);
    checks++;
    if (u_if.act_valid !== 1'b1 || u_if.act_code !== 3'd4) begin
      errors++; $display("FAIL prio_first got=%b/%0d want=1/4", u_if.act_valid, u_if.act_code);
    end
    for (int i = 0; i < 5; i++) begin
      drive(16'h2C1A, 1'b0);
      if (u_if.act_valid !== 1'b1 || u_if.act_code !== 3'd4) bad++;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL prio_stall_unstable got=%0d want=0", bad); end
    drive(16'h2C1A, 1'b1);
    checks++;
    if (u_if.act_valid !== 1'b1 || u_if.act_code !== 3'd3) begin
      errors++; $display("FAIL prio_back_to_back got=%b/%0d want=1/3", u_if.act_valid, u_if.act_code);
    end
    drive(16'h2C1A, 1'b1);
    checks++;
    if (u_if.act_valid !== 1'b0) begin errors++; $display("FAIL prio_drain got=%b want=0", u_if.act_valid); end
    settle();
  endtask

  task automatic test_coalesce();
    int bad = 0;
`ifdef KEYDEC_DROPCNT_EN
    int base = int'(dbg_drop_cnt);
    int want = ((40 - 1 - int'(DAS)) / int'(ARR)) + 1;
`endif
    for (int i = 0; i < 40; i++) begin
      drive(16'h0016, 1'b0);
      if (u_if.act_valid !== 1'b1 || u_if.act_code !== 3'd2) bad++;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL coalesce_hold got=%0d want=0", bad); end
`ifdef KEYDEC_DROPCNT_EN
    checks++;
    if (int'(dbg_drop_cnt) - base != want) begin
      errors++; $display("FAIL coalesce_dropcnt got=%0d want=%0d", int'(dbg_drop_cnt) - base, want);
    end
`endif
    drive(16'h0000, 1'b1);
    checks++;
    if (u_if.act_valid !== 1'b0) begin errors++; $display("FAIL coalesce_single got=%b want=0", u_if.act_valid); end
    settle();
  endtask

  task automatic test_reset_mid();
    int hits[$];
    repeat (4) drive(16'h0004, 1'b1);
    rst_n = 1'b0;
    #1;
    checks++;
    if (u_if.act_valid !== 1'b0 || u_if.act_code !== 3'd0 || key_held !== 5'b0) begin
      errors++; $display("FAIL midreset_async got=%b/%0d/%b want=0/0/00000", u_if.act_valid, u_if.act_code, key_held);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      drive(16'h0004, 1'b1);
      if (u_if.act_valid === 1'b1) hits.push_back(i + 1);
    end
    checks++;
    if (hits.size() != 4 || hits[0] != 1 || hits[1] != 1 + int'(DAS) || hits[3] != 1 + int'(DAS + 2 * ARR)) begin
      errors++; $display("FAIL midreset_restart got=%0d events first=%0d want=4 events first=1",
                         hits.size(), (hits.size() > 0) ? hits[0] : -1);
    end
    settle();
  endtask

  task automatic test_ignore();
    int n = 0;
    int code = -1;
    drive(16'h1A1A, 1'b1);
    if (u_if.act_valid === 1'b1) begin n++; code = int'(u_if.act_code); end
    drive(16'h0000, 1'b1);
    if (u_if.act_valid === 1'b1) n++;
    for (int i = 0; i < 6; i++) begin
      drive(16'h0800, 1'b1);
      if (u_if.act_valid === 1'b1) n++;
    end
    checks++;
    if (n != 1 || code != 3) begin errors++; $display("FAIL ignore_events got=%0d code=%0d want=1 code=3", n, code); end
    checks++;
    if (key_held !== 5'b0) begin errors++; $display("FAIL ignore_held got=%b want=00000", key_held); end
    settle();
  endtask

  task automatic test_random();
    logic [7:0] pool [7] = '{8'h00, 8'h04, 8'h07, 8'h16, 8'h1A, 8'h2C, 8'h08};
    logic [15:0] kc;
    int dur;
    int cyc = 0;
    while (cyc < 3000) begin
      kc = {pool[$urandom_range(0, 6)], pool[$urandom_range(0, 6)]};
      dur = $urandom_range(1, 24);
      for (int i = 0; i < dur; i++) begin
        drive(kc, ($urandom_range(0, 3) != 0));
        cyc++;
        checks++;
        if (u_if.act_valid !== m_valid || (m_valid && u_if.act_code !== 3'(m_code)) || key_held !== m_held) begin
          errors++;
          $display("FAIL random_cycle%0d got=%b/%0d/%b want=%b/%0d/%b", cyc, u_if.act_valid, u_if.act_code,
                   key_held, m_valid, m_code, m_held);
        end
      end
    end
    settle();
  endtask

  initial begin
    test_reset();
    test_das_repeat();
    test_cancel();
    test_priority();
    test_coalesce();
    test_reset_mid();
    test_ignore();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
